lifo_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the 4-bit LIFO stack.
- Each requester asks for a push or a pop. The block serialises the requests into single-cycle stack operations, drives the stack's `EN`/`RW`/`dataIn`, and returns pop data to the winner.
- Rejects illegal operations (push when full, pop when empty) without touching the stack.

---
 rtl/lifo_arbiter_pkg.sv | 16 +
 rtl/lifo_arbiter_rr_arb2.sv | 29 ++
 rtl/lifo_arbiter.sv | 127 ++++++++++++
 tb/tb_lifo_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arbiter_pkg.sv
// Shared definitions for the LIFO front-end arbiter: data width, op encoding
// and the sequencer state type.
package lifo_pkg;

    localparam int DATA_W = 4;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        POP_WAIT
    } lifo_arb_state_t;

endpackage

// File: rtl/lifo_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie and flips to the other side after every granted arbitration.
module rr_arb2 (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] win
);

    logic r_ptr;

    always_comb begin
        win = '0;
        if (req == 2'b11)
            win = r_ptr ? 2'b10 : 2'b01;
        else
            win = req;
    end

    // Winner 0 hands priority to 1, winner 1 hands it back to 0.
    always_ff @(posedge Clk) begin
        if (Rst)
            r_ptr <= 1'b0;
        else if (advance && (win != 2'b00))
            r_ptr <= win[0];
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Serialises push/pop requests from two requesters onto a single LIFO stack,
// rejecting push-when-full and pop-when-empty without touching the stack.
module lifo_arbiter #(
    parameter int DATA_W = lifo_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              op0,
    input  logic              op1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              err0,
    output logic              err1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              stk_EN,
    output logic              stk_RW,
    output logic [DATA_W-1:0] stk_dataIn,
    input  logic [DATA_W-1:0] stk_dataOut,
    input  logic              stk_FULL,
    input  logic              stk_EMPTY
);
    import lifo_pkg::*;

    lifo_arb_state_t   r_state;
    logic [1:0]        r_gnt;
    logic [1:0]        r_err;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_en;
    logic              r_rw;
    logic [DATA_W-1:0] r_din;
    logic              r_owner;
    logic              r_pop;

    logic [1:0]        w_win;
    logic              w_grant;
    logic              w_op;
    logic [DATA_W-1:0] w_wdata;
    logic              w_reject;

    rr_arb2 u_rr (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     ({req1, req0}),
        .advance (w_grant),
        .win     (w_win)
    );

    assign w_grant  = (r_state == IDLE) && (w_win != 2'b00);
    assign w_op     = w_win[1] ? op1 : op0;
    assign w_wdata  = w_win[1] ? wdata1 : wdata0;
    assign w_reject = (w_op == OP_POP) ? stk_EMPTY : stk_FULL;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_err    <= '0;
            r_rvalid <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_en     <= 1'b0;
            r_rw     <= 1'b0;
            r_din    <= '0;
            r_owner  <= 1'b0;
            r_pop    <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_err    <= '0;
            r_rvalid <= '0;
            r_en     <= 1'b0;
            r_rw     <= 1'b0;
            r_din    <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_gnt   <= w_win;
                        r_owner <= w_win[1];
                        r_pop   <= !w_reject && (w_op == OP_POP);
                        if (w_reject) begin
                            r_err <= w_win;
                        end else begin
                            r_en  <= 1'b1;
                            r_rw  <= w_op;
                            r_din <= (w_op == OP_PUSH) ? w_wdata : '0;
                        end
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= r_pop ? POP_WAIT : IDLE;
                end
                POP_WAIT: begin
                    // Stack output settles the cycle after the pop edge.
                    if (r_owner)
                        r_rdata1 <= stk_dataOut;
                    else
                        r_rdata0 <= stk_dataOut;
                    r_rvalid[r_owner] <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt0       = r_gnt[0];
    assign gnt1       = r_gnt[1];
    assign err0       = r_err[0];
    assign err1       = r_err[1];
    assign rvalid0    = r_rvalid[0];
    assign rvalid1    = r_rvalid[1];
    assign rdata0     = r_rdata0;
    assign rdata1     = r_rdata1;
    assign stk_EN     = r_en;
    assign stk_RW     = r_rw;
    assign stk_dataIn = r_din;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter driving a behavioural 8-deep, 4-bit LIFO,
// with a scoreboard of expected pop results checked on every rvalid pulse.
module tb_lifo_arbiter;
    import lifo_pkg::*;

    localparam int W     = 4;
    localparam int DEPTH = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [W-1:0] wdata0 = '0, wdata1 = '0;
    logic         gnt0, gnt1, err0, err1, rvalid0, rvalid1;
    logic [W-1:0] rdata0, rdata1;
    logic         stk_EN, stk_RW, stk_FULL, stk_EMPTY;
    logic [W-1:0] stk_dataIn, stk_dataOut;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_stk[$];
    int           exp_who[$];
    logic [W-1:0] exp_dat[$];

    lifo_arbiter #(.DATA_W(W)) dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .stk_EN(stk_EN), .stk_RW(stk_RW), .stk_dataIn(stk_dataIn),
        .stk_dataOut(stk_dataOut), .stk_FULL(stk_FULL), .stk_EMPTY(stk_EMPTY)
    );

    always #5 Clk = ~Clk;

    // Behavioural LIFO: pushes and pops on the EN edge, read data registered.
    logic [W-1:0] s_mem[DEPTH];
    int           s_sp = 0;
    logic [W-1:0] s_dout = '0;
    always @(posedge Clk) begin
        if (Rst) begin
            s_sp   <= 0;
            s_dout <= '0;
        end else if (stk_EN) begin
            if (!stk_RW && s_sp < DEPTH) begin
                s_mem[s_sp] <= stk_dataIn;
                s_sp        <= s_sp + 1;
            end else if (stk_RW && s_sp > 0) begin
                s_dout <= s_mem[s_sp-1];
                s_sp   <= s_sp - 1;
            end
        end
    end
    assign stk_dataOut = s_dout;
    assign stk_FULL    = (s_sp == DEPTH);
    assign stk_EMPTY   = (s_sp == 0);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Rst && (rvalid0 || rvalid1)) begin
            if (exp_who.size() == 0) begin
                chk("rvalid_unexpected", {rvalid1, rvalid0}, 16'h0);
            end else begin
                int           who;
                logic [W-1:0] d;
                who = exp_who.pop_front();
                d   = exp_dat.pop_front();
                chk("rvalid_owner", {rvalid1, rvalid0}, (who == 0) ? 16'h1 : 16'h2);
                chk("rdata", (who == 0) ? rdata0 : rdata1, d);
            end
        end
    end

    task automatic drive(input int n, input logic v, input logic op, input logic [W-1:0] d);
        if (n == 0) begin
            req0 = v; op0 = op; wdata0 = d;
        end else begin
            req1 = v; op1 = op; wdata1 = d;
        end
    endtask

    task automatic wait_gnt(input int n, output logic seen, output int k);
        seen = 1'b0;
        k    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            k++;
            if ((n == 0) ? gnt0 : gnt1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        m_stk.delete();
        exp_who.delete();
        exp_dat.delete();
    endtask

    task automatic do_op(input int n, input logic op, input logic [W-1:0] d);
        logic         rej, seen;
        int           k;
        logic [W-1:0] e;
        rej = (op == OP_POP) ? (m_stk.size() == 0) : (m_stk.size() == DEPTH);
        drive(n, 1'b1, op, d);
        wait_gnt(n, seen, k);
        chk("gnt_seen", seen, 1);
        drive(n, 1'b0, op, d);
        if (seen) begin
            chk("err", (n == 0) ? err0 : err1, rej);
            chk("other_gnt", (n == 0) ? gnt1 : gnt0, 0);
            chk("stk_EN", stk_EN, !rej);
            chk("stk_RW", stk_RW, rej ? 1'b0 : op);
            chk("stk_dataIn", stk_dataIn, (!rej && op == OP_PUSH) ? d : 4'h0);
            if (!rej) begin
                if (op == OP_PUSH) begin
                    m_stk.push_back(d);
                end else begin
                    e = m_stk.pop_back();
                    exp_who.push_back(n);
                    exp_dat.push_back(e);
                end
            end
            @(negedge Clk);
            chk("cycle1_quiet", {gnt0, gnt1, stk_EN, rvalid0, rvalid1}, 0);
            if (op == OP_POP) begin
                @(negedge Clk);
                chk("rvalid_timing", (n == 0) ? rvalid0 : rvalid1, !rej);
            end
        end
    endtask

    initial begin
        logic seen;
        int   k;

        // Reset held two cycles with both requesters pushing.
        drive(0, 1'b1, OP_PUSH, 4'h1);
        drive(1, 1'b1, OP_PUSH, 4'h3);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("reset_outputs", {gnt0, gnt1, err0, err1, rvalid0, rvalid1,
                                  stk_EN, stk_RW, stk_dataIn, rdata0}, 0);
            chk("reset_rdata1", rdata1, 0);
        end
        Rst = 1'b0;
        wait_gnt(0, seen, k);
        chk("reset_first_gnt0", {seen, gnt1}, 16'h2);
        chk("reset_first_latency", k, 1);
        drive(0, 1'b0, OP_PUSH, 4'h1);
        m_stk.push_back(4'h1);
        wait_gnt(1, seen, k);
        chk("reset_second_gnt1", seen, 1);
        drive(1, 1'b0, OP_PUSH, 4'h3);
        m_stk.push_back(4'h3);
        @(negedge Clk);
        do_op(0, OP_POP, 4'h0);

        // Single pushes then a pop from the other requester.
        do_reset();
        do_op(0, OP_PUSH, 4'h2);
        do_op(0, OP_PUSH, 4'h4);
        do_op(1, OP_POP, 4'h0);
        do_op(0, OP_POP, 4'h0);

        // Simultaneous pushes: requester 0 first, requester 1 two cycles later.
        do_reset();
        @(negedge Clk);
        drive(0, 1'b1, OP_PUSH, 4'h6);
        drive(1, 1'b1, OP_PUSH, 4'h9);
        wait_gnt(0, seen, k);
        chk("contend_gnt0", {seen, gnt1}, 16'h2);
        drive(0, 1'b0, OP_PUSH, 4'h6);
        m_stk.push_back(4'h6);
        wait_gnt(1, seen, k);
        chk("contend_gnt1_gap", {seen, 8'(k)}, 16'h102);
        chk("contend_dataIn", stk_dataIn, 4'h9);
        drive(1, 1'b0, OP_PUSH, 4'h9);
        m_stk.push_back(4'h9);
        @(negedge Clk);
        do_op(0, OP_POP, 4'h0);
        do_op(1, OP_POP, 4'h0);

        // Pop on an empty stack is rejected.
        do_reset();
        do_op(1, OP_POP, 4'h0);

        // Fill to full; the extra push is rejected and never lands.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_op(0, OP_PUSH, 4'(i + 1));
        chk("stk_full", stk_FULL, 1);
        do_op(0, OP_PUSH, 4'hA);
        do_op(1, OP_POP, 4'h0);

        // Reset during POP_WAIT: no rvalid, pointer back to requester 0.
        do_reset();
        do_op(1, OP_PUSH, 4'h5);
        drive(0, 1'b1, OP_POP, 4'h0);
        wait_gnt(0, seen, k);
        chk("midpop_gnt0", seen, 1);
        chk("midpop_stk_EN", stk_EN, 1);
        drive(0, 1'b0, OP_POP, 4'h0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk("midpop_no_rvalid", {rvalid0, rvalid1, gnt0, gnt1, stk_EN}, 0);
        Rst = 1'b0;
        m_stk.delete();
        exp_who.delete();
        exp_dat.delete();
        @(negedge Clk);
        chk("midpop_still_no_rvalid", {rvalid0, rvalid1}, 0);
        drive(0, 1'b1, OP_PUSH, 4'h7);
        drive(1, 1'b1, OP_PUSH, 4'h8);
        wait_gnt(0, seen, k);
        chk("midpop_ptr_reset", {seen, gnt1, 8'(k)}, 16'h201);
        drive(0, 1'b0, OP_PUSH, 4'h7);
        wait_gnt(1, seen, k);
        drive(1, 1'b0, OP_PUSH, 4'h8);
        chk("midpop_then_gnt1", seen, 1);

        repeat (4) @(negedge Clk);
        chk("scoreboard_drained", exp_who.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
